// File: rtl/aux_seg_scanner_pkg.sv
// Shared display definitions for the auxiliary display blocks.
// Holds the scanner state encoding and the hex-to-segment table.
// Seven-segment bit order is {g,f,e,d,c,b,a}, active high. Every display
// block takes that order from here.
package aux_seg_scanner_pkg;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } scan_state_e;

  localparam logic [7:0] SEG_OFF = 8'hFF;

  function automatic logic [6:0] hex7(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'h3F;
      4'h1: seg = 7'h06;
      4'h2: seg = 7'h5B;
      4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66;
      4'h5: seg = 7'h6D;
      4'h6: seg = 7'h7D;
      4'h7: seg = 7'h07;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h6F;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h7C;
      4'hC: seg = 7'h39;
      4'hD: seg = 7'h5E;
      4'hE: seg = 7'h79;
      default: seg = 7'h71;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/aux_seg_scanner_if.sv
// Display bus between the divider/value source and the segment scanner.
//   div_in   : divided square wave, synchronous to clk
//   val      : 4*NumDigit hex value, nibble i on digit i
//   dp_en    : per-digit decimal point enable, 1 = lit
//   blank_en : per-digit blank, 1 = anode held off
//   seg_n    : cathodes, active low, {dp,g,f,e,d,c,b,a}
//   an_n     : anodes, active low, one-hot-low while showing
//   frame    : one-cycle pulse when the value is captured
// master drives the inputs of the scanner; slave is the scanner itself.
interface aux_seg_scanner_if #(
  parameter int unsigned NumDigit = 8
);
  logic                  div_in;
  logic [4*NumDigit-1:0] val;
  logic [NumDigit-1:0]   dp_en;
  logic [NumDigit-1:0]   blank_en;
  logic [7:0]            seg_n;
  logic [NumDigit-1:0]   an_n;
  logic                  frame;

  modport master (
    output div_in, val, dp_en, blank_en,
    input  seg_n, an_n, frame
  );

  modport slave (
    input  div_in, val, dp_en, blank_en,
    output seg_n, an_n, frame
  );
endinterface

// File: rtl/aux_hex7seg.sv
// Combinational hex digit to seven-segment decoder.
//   nib : 4-bit hex digit
//   seg : segments {g,f,e,d,c,b,a}, active high
module aux_hex7seg
  import aux_seg_scanner_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  always_comb begin
    seg = hex7(nib);
  end

endmodule

// File: rtl/aux_load_cnt.sv
// Auxiliary loadable down counter.
//   clk, rst : clock, asynchronous active-high reset (to RstVal)
//   load     : load load_val (wins over dec)
//   load_val : value to load
//   dec      : decrement, saturating at zero
//   cnt      : current count
module aux_load_cnt #(
  parameter int unsigned       Width  = 4,
  parameter logic [Width-1:0]  RstVal = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [Width-1:0] load_val,
  input  logic             dec,
  output logic [Width-1:0] cnt
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= RstVal;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/aux_seg_scanner.sv
// Multiplexes a NumDigit-digit hex value onto a common-anode seven-segment
// display, one digit per rising edge of the divided wave, with an
// all-anodes-off dead time after every advance. The value, decimal points
// and blanks are captured only when the digit index wraps to 0.
//   clk, rst : system clock, asynchronous active-high reset
//   bus      : aux_seg_scanner_if slave (div_in, val, dp_en, blank_en in;
//              seg_n, an_n, frame out)
module aux_seg_scanner
  import aux_seg_scanner_pkg::*;
#(
  parameter int unsigned NumDigit = 8,
  parameter int unsigned BlankCyc = 4
) (
  input  logic             clk,
  input  logic             rst,
  aux_seg_scanner_if.slave bus
);

  localparam int unsigned          IdxW    = (NumDigit > 1) ? $clog2(NumDigit) : 1;
  localparam int unsigned          CntW    = (BlankCyc > 0) ? $clog2(BlankCyc + 1) : 1;
  localparam logic [IdxW-1:0]      LastIdx = IdxW'(NumDigit - 1);
  localparam logic [CntW-1:0]      BlankLd = CntW'(BlankCyc);
  localparam logic [NumDigit-1:0]  Digit0  = {{(NumDigit-1){1'b0}}, 1'b1};

  logic                  div_q;
  logic                  adv;
  logic                  wrap;
  logic [IdxW-1:0]       idx;
  logic [IdxW-1:0]       nxt_idx;
  scan_state_e           state;
  scan_state_e           nxt_state;
  logic [CntW-1:0]       cnt;
  logic [4*NumDigit-1:0] lat_val;
  logic [4*NumDigit-1:0] nxt_val;
  logic [NumDigit-1:0]   lat_dp;
  logic [NumDigit-1:0]   nxt_dp;
  logic [NumDigit-1:0]   lat_blank;
  logic [NumDigit-1:0]   nxt_blank;
  logic [3:0]            nib;
  logic                  nib_dp;
  logic                  nib_blank;
  logic                  idx_ok;
  logic [6:0]            seg_hi;

  aux_load_cnt #(
    .Width  (CntW),
    .RstVal (BlankLd)
  ) u_dead_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (adv),
    .load_val (BlankLd),
    .dec      (state == ST_BLANK),
    .cnt      (cnt)
  );

  aux_hex7seg u_hex (
    .nib (nib),
    .seg (seg_hi)
  );

  // Outputs are registered from the next-cycle index/state/latches so the
  // pins change on the same edge as the scan state, without a pipeline lag.
  // Dead time runs while the counter reads BlankCyc..0, i.e. BlankCyc+1
  // blank cycles; BlankCyc = 0 skips BLANK entirely on an advance.
  always_comb begin
    adv       = bus.div_in & ~div_q;
    wrap      = adv && (idx == LastIdx);
    nxt_idx   = idx;
    if (adv) begin
      nxt_idx = wrap ? '0 : idx + 1'b1;
    end
    nxt_val   = wrap ? bus.val      : lat_val;
    nxt_dp    = wrap ? bus.dp_en    : lat_dp;
    nxt_blank = wrap ? bus.blank_en : lat_blank;

    nxt_state = state;
    if (adv) begin
      nxt_state = (BlankCyc == 0) ? ST_SHOW : ST_BLANK;
    end else if ((state == ST_BLANK) && (cnt == '0)) begin
      nxt_state = ST_SHOW;
    end

    // Unused index codes fall through to the defaults and decode as blank.
    nib       = '0;
    nib_dp    = 1'b0;
    nib_blank = 1'b1;
    idx_ok    = 1'b0;
    for (int unsigned i = 0; i < NumDigit; i++) begin
      if (nxt_idx == IdxW'(i)) begin
        nib       = nxt_val[4*i +: 4];
        nib_dp    = nxt_dp[i];
        nib_blank = nxt_blank[i];
        idx_ok    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q      <= 1'b0;
      idx        <= '0;
      state      <= ST_BLANK;
      lat_val    <= '0;
      lat_dp     <= '0;
      lat_blank  <= '0;
      bus.seg_n  <= SEG_OFF;
      bus.an_n   <= '1;
      bus.frame  <= 1'b0;
    end else begin
      div_q      <= bus.div_in;
      idx        <= nxt_idx;
      state      <= nxt_state;
      lat_val    <= nxt_val;
      lat_dp     <= nxt_dp;
      lat_blank  <= nxt_blank;
      bus.frame  <= wrap;
      if ((nxt_state == ST_SHOW) && idx_ok) begin
        bus.seg_n <= ~{nib_dp, seg_hi};
        bus.an_n  <= nib_blank ? '1 : ~(Digit0 << nxt_idx);
      end else begin
        bus.seg_n <= SEG_OFF;
        bus.an_n  <= '1;
      end
    end
  end

endmodule

// File: tb/tb_aux_seg_scanner.sv
module tb_aux_seg_scanner;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  aux_seg_scanner_if #(.NumDigit(8)) bus8 ();
  aux_seg_scanner_if #(.NumDigit(5)) bus5 ();

  aux_seg_scanner #(.NumDigit(8), .BlankCyc(4)) u_dut8 (
    .clk (clk),
    .rst (rst),
    .bus (bus8)
  );

  aux_seg_scanner #(.NumDigit(5), .BlankCyc(0)) u_dut5 (
    .clk (clk),
    .rst (rst),
    .bus (bus5)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic adv8;
    bus8.div_in = 1'b1;
    tick();
    bus8.div_in = 1'b0;
  endtask

  task automatic adv5;
    bus5.div_in = 1'b1;
    tick();
    bus5.div_in = 1'b0;
  endtask

  // One advance on the 8-digit scanner: 5 dead cycles, then the digit.
  task automatic show8(input string tag, input logic [7:0] an, input logic [7:0] seg,
                       input logic frm);
    adv8();
    chk({tag, "_frame"}, bus8.frame, frm);
    for (int k = 0; k < 5; k++) begin
      chk({tag, "_dead_an"}, bus8.an_n, 8'hFF);
      chk({tag, "_dead_seg"}, bus8.seg_n, 8'hFF);
      tick();
    end
    chk({tag, "_an"}, bus8.an_n, an);
    chk({tag, "_seg"}, bus8.seg_n, seg);
    chk({tag, "_frame_low"}, bus8.frame, 1'b0);
  endtask

  // One advance on the 5-digit, no-dead-time scanner.
  task automatic show5(input string tag, input logic [4:0] an, input logic [7:0] seg,
                       input logic frm);
    adv5();
    chk({tag, "_an"}, bus5.an_n, an);
    chk({tag, "_seg"}, bus5.seg_n, seg);
    chk({tag, "_frame"}, bus5.frame, frm);
    tick();
    chk({tag, "_hold_an"}, bus5.an_n, an);
    chk({tag, "_frame_low"}, bus5.frame, 1'b0);
  endtask

  logic [7:0] seg_f [8];
  logic [7:0] an8;
  logic [4:0] an5;
  logic [7:0] seg5 [5];

  initial begin
    seg_f = '{8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80};
    seg5  = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99};

    rst           = 1'b1;
    bus8.div_in   = 1'b0;
    bus8.val      = '0;
    bus8.dp_en    = '0;
    bus8.blank_en = '0;
    bus5.div_in   = 1'b0;
    bus5.val      = '0;
    bus5.dp_en    = '0;
    bus5.blank_en = '0;

    // Reset held while div_in toggles
    for (int k = 0; k < 6; k++) begin
      bus8.div_in = k[0];
      bus5.div_in = k[0];
      tick();
      chk("rst_seg", bus8.seg_n, 8'hFF);
      chk("rst_an", bus8.an_n, 8'hFF);
      chk("rst_frame", bus8.frame, 1'b0);
      chk("rst5_an", bus5.an_n, 5'h1F);
      chk("rst5_seg", bus5.seg_n, 8'hFF);
    end
    bus8.div_in = 1'b0;
    bus5.div_in = 1'b0;
    tick();
    rst = 1'b0;

    // Advance, then asynchronous reset in the middle of the dead time
    adv8();
    chk("pre_rst_blank", bus8.an_n, 8'hFF);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_an", bus8.an_n, 8'hFF);
    chk("async_rst_seg", bus8.seg_n, 8'hFF);
    chk("async_rst_frame", bus8.frame, 1'b0);
    tick();
    rst = 1'b0;

    // Idle after reset: dead time expires, digit 0 of a zero value
    for (int k = 0; k < 6; k++) tick();
    chk("idle_d0_an", bus8.an_n, 8'hFE);
    chk("idle_d0_seg", bus8.seg_n, 8'hC0);
    chk("idle5_an", bus5.an_n, 5'h1E);
    chk("idle5_seg", bus5.seg_n, 8'hC0);

    show8("t1_d1", 8'hFD, 8'hC0, 1'b0);

    // Main scan: value only becomes visible after the wrap
    bus8.val = 32'h89AB_CDEF;
    for (int d = 2; d < 8; d++) begin
      an8 = ~(8'h01 << d);
      show8("t2_old", an8, 8'hC0, 1'b0);
    end
    show8("t2_wrap", 8'hFE, 8'h8E, 1'b1);
    for (int d = 1; d < 8; d++) begin
      an8 = ~(8'h01 << d);
      show8("t2_dig", an8, seg_f[d], 1'b0);
    end

    // Mid-frame value change is invisible until the next wrap
    show8("t3_wrap", 8'hFE, 8'h8E, 1'b1);
    for (int d = 1; d < 4; d++) begin
      an8 = ~(8'h01 << d);
      show8("t3_pre", an8, seg_f[d], 1'b0);
    end
    bus8.val = 32'h0;
    for (int d = 4; d < 8; d++) begin
      an8 = ~(8'h01 << d);
      show8("t3_keep", an8, seg_f[d], 1'b0);
    end
    show8("t3_new", 8'hFE, 8'hC0, 1'b1);

    // Blank and decimal point, captured at the following wrap
    bus8.val      = 32'h7654_3210;
    bus8.dp_en    = 8'h01;
    bus8.blank_en = 8'h04;
    for (int d = 1; d < 8; d++) begin
      an8 = ~(8'h01 << d);
      show8("t4_old", an8, 8'hC0, 1'b0);
    end
    show8("t4_dp", 8'hFE, 8'h40, 1'b1);
    show8("t4_d1", 8'hFD, 8'hF9, 1'b0);
    show8("t4_blank", 8'hFF, 8'hA4, 1'b0);
    show8("t4_d3", 8'hF7, 8'hB0, 1'b0);

    // Second advance inside the dead time restarts it; digit 4 is skipped
    adv8();
    chk("t5_dead1", bus8.an_n, 8'hFF);
    tick();
    chk("t5_dead2", bus8.an_n, 8'hFF);
    show8("t5_d5", 8'hDF, 8'h92, 1'b0);

    // NumDigit=5, BlankCyc=0
    bus5.val = 20'h4_3210;
    for (int d = 1; d < 5; d++) begin
      an5 = ~(5'h01 << d);
      show5("t6_old", an5, 8'hC0, 1'b0);
    end
    show5("t6_wrap", 5'h1E, 8'hC0, 1'b1);
    for (int d = 1; d < 5; d++) begin
      an5 = ~(5'h01 << d);
      show5("t6_dig", an5, seg5[d], 1'b0);
    end
    show5("t6_wrap2", 5'h1E, 8'hC0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
